pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Detects RAW hazards on the two register sources of the instruction in ID.
- Drives `hazard_detected` into the ID stage, which then emits a bubble.
- Generates freeze/flush controls for the PC and every pipeline register. Handles multi-cycle data-memory waits with a timeout watchdog, and keeps saturating performance counters.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_detector.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard sequencer.
package hazard_pkg;

  // Sequencer states: normal flow, waiting on data memory, dead after watchdog expiry.
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_TIMEOUT  = 2'd2
  } hazard_state_t;

  localparam int DEFAULT_CNT_W = 32;

  // Counters are widened to this before the saturating increment, then truncated back.
  localparam int SAT_W = 64;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max_value);
    logic [SAT_W-1:0] result;
    if (value >= max_value) begin
      result = max_value;
    end else begin
      result = value + SAT_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/hazard_detector.sv
// Combinational RAW hazard detection for the instruction sitting in ID.
// Register 0 is hardwired to zero, so a destination of 0 never matches.
module hazard_detector
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  forward_en,
  output logic                  raw
);

  logic exe_match;
  logic mem_match;

  // Source 2 only counts when the instruction really reads it.
  assign exe_match = (exe_dest != '0) &&
                     ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
  assign mem_match = (mem_dest != '0) &&
                     ((mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2)));

  // With forwarding only a load in EXE cannot be bypassed; without it any pending write stalls.
  always_comb begin
    raw = 1'b0;
    if (forward_en) begin
      raw = exe_mem_r_en && exe_match;
    end else begin
      raw = (exe_wb_en && exe_match) || (mem_wb_en && mem_match);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW bubbles, branch flush,
// data-memory wait freezes with a watchdog, and saturating performance counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_br_taken,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  forward_en,
  input  logic                  mem_busy,
  input  logic                  clr_cnt,
  output logic                  hazard_detected,
  output logic                  pc_freeze,
  output logic                  ifid_freeze,
  output logic                  ifid_flush,
  output logic                  idex_freeze,
  output logic                  exmem_freeze,
  output logic                  memwb_freeze,
  output logic                  err_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      memwait_cnt
);

  // The timer only has to reach TIMEOUT; one spare bit keeps the compare clean.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 2) : 1;
  localparam logic [TW-1:0]    TIMEOUT_V = TW'(TIMEOUT);
  localparam logic [SAT_W-1:0] CNT_MAX   = SAT_W'({CNT_W{1'b1}});

  hazard_state_t state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic          raw;
  logic          watchdog_hit;
  logic          mem_stall;

  hazard_detector #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_detector (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .exe_dest     (exe_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .forward_en   (forward_en),
    .raw          (raw)
  );

  // Timer counts consecutive busy cycles; it saturates so a disabled watchdog cannot wrap it.
  assign timer_inc    = (&timer) ? timer : timer + TW'(1);
  assign watchdog_hit = (TIMEOUT != 0) && (timer_inc >= TIMEOUT_V);

  // Mealy control outputs; memory waits outrank RAW bubbles, which outrank branch flushes.
  always_comb begin
    hazard_detected = 1'b0;
    pc_freeze       = 1'b0;
    ifid_freeze     = 1'b0;
    ifid_flush      = 1'b0;
    idex_freeze     = 1'b0;
    exmem_freeze    = 1'b0;
    memwb_freeze    = 1'b0;
    mem_stall       = 1'b0;
    if (rst) begin
      if ((state == S_TIMEOUT) || mem_busy) begin
        pc_freeze    = 1'b1;
        ifid_freeze  = 1'b1;
        idex_freeze  = 1'b1;
        exmem_freeze = 1'b1;
        memwb_freeze = 1'b1;
        mem_stall    = 1'b1;
      end else begin
        hazard_detected = raw;
        pc_freeze       = raw;
        ifid_freeze     = raw;
        ifid_flush      = id_br_taken && !raw;
      end
    end
  end

  // Sequencer state, busy timer and the sticky watchdog error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_RUN;
      timer       <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_RUN, S_MEM_WAIT: begin
          if (mem_busy) begin
            timer <= timer_inc;
            if (watchdog_hit) begin
              state       <= S_TIMEOUT;
              err_timeout <= 1'b1;
            end else begin
              state <= S_MEM_WAIT;
            end
          end else begin
            state <= S_RUN;
            timer <= '0;
          end
        end
        S_TIMEOUT: begin
          state       <= S_TIMEOUT;
          err_timeout <= 1'b1;
        end
        default: begin
          state <= S_RUN;
          timer <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters; a clear request wins over any increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (hazard_detected) begin
        stall_cnt <= CNT_W'(sat_inc(SAT_W'(stall_cnt), CNT_MAX));
      end
      if (ifid_flush) begin
        flush_cnt <= CNT_W'(sat_inc(SAT_W'(flush_cnt), CNT_MAX));
      end
      if (mem_stall) begin
        memwait_cnt <= CNT_W'(sat_inc(SAT_W'(memwait_cnt), CNT_MAX));
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the sequencer.
module tb_pipe_hazard_ctrl;

  localparam int RW      = 5;
  localparam int CW      = 4;
  localparam int TO      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
  logic          id_two_src = 1'b0, id_br_taken = 1'b0, exe_wb_en = 1'b0, exe_mem_r_en = 1'b0;
  logic          mem_wb_en = 1'b0, forward_en = 1'b0, mem_busy = 1'b0, clr_cnt = 1'b0;
  logic          hazard_detected, pc_freeze, ifid_freeze, ifid_flush;
  logic          idex_freeze, exmem_freeze, memwb_freeze, err_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model: dead flag, consecutive busy run, counters as plain integers.
  bit m_dead;
  int m_run;
  int m_stall, m_flush, m_wait;
  bit e_haz, e_pcf, e_ifidf, e_flush, e_idex, e_exmem, e_memwb, e_wait;

  pipe_hazard_ctrl #(
    .REG_ADDR_W(RW),
    .CNT_W     (CW),
    .TIMEOUT   (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_src1        (id_src1),
    .id_src2        (id_src2),
    .id_two_src     (id_two_src),
    .id_br_taken    (id_br_taken),
    .exe_wb_en      (exe_wb_en),
    .exe_mem_r_en   (exe_mem_r_en),
    .exe_dest       (exe_dest),
    .mem_wb_en      (mem_wb_en),
    .mem_dest       (mem_dest),
    .forward_en     (forward_en),
    .mem_busy       (mem_busy),
    .clr_cnt        (clr_cnt),
    .hazard_detected(hazard_detected),
    .pc_freeze      (pc_freeze),
    .ifid_freeze    (ifid_freeze),
    .ifid_flush     (ifid_flush),
    .idex_freeze    (idex_freeze),
    .exmem_freeze   (exmem_freeze),
    .memwb_freeze   (memwb_freeze),
    .err_timeout    (err_timeout),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .memwait_cnt    (memwait_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [RW-1:0] s1, input logic [RW-1:0] s2, input bit two,
                               input bit br, input bit fwd, input bit ewb, input bit eld,
                               input logic [RW-1:0] ed, input bit mwb, input logic [RW-1:0] md,
                               input bit busy, input bit clr);
    id_src1 = s1; id_src2 = s2; id_two_src = two; id_br_taken = br; forward_en = fwd;
    exe_wb_en = ewb; exe_mem_r_en = eld; exe_dest = ed; mem_wb_en = mwb; mem_dest = md;
    mem_busy = busy; clr_cnt = clr;
  endtask

  function automatic bit reads(input logic [RW-1:0] d);
    return (d != 0) && ((d == id_src1) || (id_two_src && (d == id_src2)));
  endfunction

  function automatic int satAdd(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic predict();
    bit r;
    {e_haz, e_pcf, e_ifidf, e_flush, e_idex, e_exmem, e_memwb, e_wait} = '0;
    if (rst === 1'b1) begin
      if (m_dead || mem_busy) begin
        {e_pcf, e_ifidf, e_idex, e_exmem, e_memwb, e_wait} = '1;
      end else begin
        if (forward_en) r = exe_mem_r_en && reads(exe_dest);
        else            r = (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
        e_haz = r; e_pcf = r; e_ifidf = r;
        e_flush = id_br_taken && !r;
      end
    end
  endtask

  task automatic checkComb(input string tag);
    checkOutput({tag, ".hazard"}, 32'(hazard_detected), 32'(e_haz));
    checkOutput({tag, ".pc_frz"}, 32'(pc_freeze), 32'(e_pcf));
    checkOutput({tag, ".ifid_frz"}, 32'(ifid_freeze), 32'(e_ifidf));
    checkOutput({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(e_flush));
    checkOutput({tag, ".idex_frz"}, 32'(idex_freeze), 32'(e_idex));
    checkOutput({tag, ".exmem_frz"}, 32'(exmem_freeze), 32'(e_exmem));
    checkOutput({tag, ".memwb_frz"}, 32'(memwb_freeze), 32'(e_memwb));
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    checkOutput({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
    checkOutput({tag, ".memwait_cnt"}, 32'(memwait_cnt), 32'(m_wait));
    checkOutput({tag, ".err_timeout"}, 32'(err_timeout), 32'(m_dead));
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at the edge, check registers.
  task automatic runCycle(input string tag);
    @(negedge clk);
    predict();
    checkComb(tag);
    @(posedge clk);
    if (clr_cnt) begin
      m_stall = 0; m_flush = 0; m_wait = 0;
    end else begin
      if (e_haz)   m_stall = satAdd(m_stall);
      if (e_flush) m_flush = satAdd(m_flush);
      if (e_wait)  m_wait  = satAdd(m_wait);
    end
    if (!m_dead) begin
      if (mem_busy) begin
        m_run++;
        if (m_run >= TO) m_dead = 1;
      end else begin
        m_run = 0;
      end
    end
    #1;
    checkRegs(tag);
  endtask

  // Asserts reset in the middle of a cycle and checks everything clears without a clock edge.
  task automatic doReset(input string tag);
    #3;
    rst = 1'b0;
    m_dead = 0; m_run = 0; m_stall = 0; m_flush = 0; m_wait = 0;
    #1;
    predict();
    checkComb({tag, ".async"});
    checkRegs({tag, ".async"});
    @(negedge clk);
    predict();
    checkComb({tag, ".held"});
    @(posedge clk);
    #1;
    checkRegs({tag, ".held"});
    rst = 1'b1;
  endtask

  task automatic clearCounters();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    runCycle("clr");
  endtask

  initial begin
    // Reset with every event input active, so forcing to zero is visible.
    applyStimulus(5, 5, 1, 1, 1, 1, 1, 5, 1, 5, 1, 0);
    doReset("rst0");

    // Load-use with forwarding: one-cycle bubble.
    clearCounters();
    applyStimulus(5, 0, 0, 0, 1, 1, 1, 5, 0, 0, 0, 0);
    runCycle("lu");
    applyStimulus(5, 0, 0, 0, 1, 0, 0, 0, 1, 5, 0, 0);
    runCycle("lu_after");
    checkOutput("lu_stall_total", 32'(stall_cnt), 32'd1);

    // No forwarding: MEM write to r7 vs ID source 2.
    applyStimulus(1, 7, 1, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    runCycle("nofwd_two");
    applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    runCycle("nofwd_one");
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    runCycle("nofwd_r0");

    // Branch with stale operands is ignored, then taken once the hazard clears.
    clearCounters();
    applyStimulus(3, 0, 0, 1, 1, 1, 1, 3, 0, 0, 0, 0);
    runCycle("br_raw");
    applyStimulus(3, 0, 0, 1, 1, 0, 0, 0, 1, 3, 0, 0);
    runCycle("br_go");
    checkOutput("br_flush_total", 32'(flush_cnt), 32'd1);

    // Three-cycle memory wait overlapping a load-use hazard.
    clearCounters();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6, 0, 0, 0, 1, 1, 1, 6, 0, 0, 1, 0);
      runCycle("mw_busy");
    end
    applyStimulus(6, 0, 0, 0, 1, 1, 1, 6, 0, 0, 0, 0);
    runCycle("mw_done");
    checkOutput("mw_wait_total", 32'(memwait_cnt), 32'd3);

    // Watchdog expiry after TO busy cycles; freezes persist until reset.
    clearCounters();
    for (int i = 0; i < TO; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      runCycle("to_busy");
    end
    checkOutput("to_err", 32'(err_timeout), 32'd1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2, 0, 0, 1, 1, 1, 1, 2, 0, 0, 0, 0);
      runCycle("to_dead");
    end
    doReset("to_rst");

    // Counter saturation, then clear while the hazard is still present.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(9, 0, 0, 0, 1, 1, 1, 9, 0, 0, 0, 0);
      runCycle("sat");
    end
    checkOutput("sat_stall_max", 32'(stall_cnt), 32'd15);
    applyStimulus(9, 0, 0, 0, 1, 1, 1, 9, 0, 0, 0, 1);
    runCycle("sat_clr");
    checkOutput("sat_stall_clr", 32'(stall_cnt), 32'd0);

    // Random traffic with small register numbers so matches are frequent.
    for (int i = 0; i < 2000; i++) begin
      if ((i % 250) == 249) begin
        doReset("rnd_rst");
      end
      applyStimulus(RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), RW'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), RW'($urandom_range(0, 7)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
      runCycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
